// File: rtl/snake_move_ctrl.sv
// Snake movement controller: step timer, direction latching, segment store,
// wall/self collision detection and a registered cell probe for the display.
`timescale 1ns/1ps
module snake_move_ctrl #(
  parameter int TICK_DIV = 12_500_000,
  parameter int MAX_LEN  = 16
) (
  input  logic       Clk_50mhz,
  input  logic       Rst_n,
  input  logic       Key_up,
  input  logic       Key_down,
  input  logic       Key_left,
  input  logic       Key_right,
  input  logic       Restart,
  input  logic       Body_add_sig,
  input  logic [5:0] Query_x,
  input  logic [4:0] Query_y,
  output logic [5:0] Head_x,
  output logic [5:0] Head_y,
  output logic [4:0] Snake_len,
  output logic       Move_tick,
  output logic       Game_over,
  output logic       Is_head,
  output logic       Is_body
);

  // state    | meaning
  // S_IDLE   | waiting for first direction key, snake parked at start cell
  // S_RUN    | tick counter running, one move per TICK_DIV cycles
  // S_DEAD   | collision seen, everything frozen until Restart

  localparam int            CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_e;
  // Encoding chosen so that the opposite direction is the LSB flipped.
  typedef enum logic [1:0] {D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3} dir_e;

  state_e        state_q;
  dir_e          dir_q;
  dir_e          pend_q;
  logic          pend_vld_q;
  logic          grow_q;
  logic [CW-1:0] tick_q;
  logic [4:0]    len_q;
  logic [5:0]    seg_x_q [MAX_LEN];
  logic [4:0]    seg_y_q [MAX_LEN];
  logic          move_tick_q;
  logic          is_head_q;
  logic          is_body_q;

  logic          key_any;
  dir_e          key_dir;
  logic          key_ok;
  dir_e          eff_dir;
  logic [5:0]    head_x_d;
  logic [4:0]    head_y_d;
  logic          wall_hit;
  logic          self_hit;
  logic          body_hit;
  logic          grow_apply;
  logic [4:0]    hit_lim;
  logic          step;
  logic          restart;

  // Key priority and reversal filter against the committed direction.
  always_comb begin
    key_any = Key_up | Key_down | Key_left | Key_right;
    if (Key_up)          key_dir = D_UP;
    else if (Key_down)   key_dir = D_DOWN;
    else if (Key_left)   key_dir = D_LEFT;
    else                 key_dir = D_RIGHT;
    key_ok  = key_any && (key_dir != dir_e'(dir_q ^ 2'b01));
    // A key arriving in the step cycle itself still counts as the first key.
    if (pend_vld_q)      eff_dir = pend_q;
    else if (key_ok)     eff_dir = key_dir;
    else                 eff_dir = dir_q;
    step    = (state_q == S_RUN) && (tick_q == TICK_LAST);
    restart = (state_q == S_DEAD) && Restart;
  end

  // Candidate next head cell and wall check (underflow caught before subtracting).
  always_comb begin
    head_x_d = seg_x_q[0];
    head_y_d = seg_y_q[0];
    wall_hit = 1'b0;
    case (eff_dir)
      D_UP:    if (seg_y_q[0] == 5'd0)  wall_hit = 1'b1; else head_y_d = seg_y_q[0] - 5'd1;
      D_DOWN:  if (seg_y_q[0] >= 5'd29) wall_hit = 1'b1; else head_y_d = seg_y_q[0] + 5'd1;
      D_LEFT:  if (seg_x_q[0] == 6'd0)  wall_hit = 1'b1; else head_x_d = seg_x_q[0] - 6'd1;
      default: if (seg_x_q[0] >= 6'd39) wall_hit = 1'b1; else head_x_d = seg_x_q[0] + 6'd1;
    endcase
  end

  // Self collision: the tail cell is excluded when it vacates (no growth this step).
  always_comb begin
    grow_apply = (grow_q | Body_add_sig) && (len_q < LEN_MAX);
    hit_lim    = grow_apply ? len_q : len_q - 5'd1;
    self_hit   = 1'b0;
    body_hit   = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((5'(i) < hit_lim) && (seg_x_q[i] == head_x_d) && (seg_y_q[i] == head_y_d))
        self_hit = 1'b1;
      if ((5'(i) < len_q) && (seg_x_q[i] == Query_x) && (seg_y_q[i] == Query_y))
        body_hit = 1'b1;
    end
  end

  // Game FSM, step timer, direction latching and segment store.
  always_ff @(posedge Clk_50mhz) begin
    if (!Rst_n || restart) begin
      state_q     <= S_IDLE;
      dir_q       <= D_RIGHT;
      pend_q      <= D_RIGHT;
      pend_vld_q  <= 1'b0;
      grow_q      <= 1'b0;
      tick_q      <= '0;
      len_q       <= 5'd3;
      move_tick_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i == 0) ? 6'd28 : (i == 1) ? 6'd27 : (i == 2) ? 6'd26 : 6'd0;
        seg_y_q[i] <= (i < 3) ? 5'd13 : 5'd0;
      end
    end else begin
      move_tick_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_any) begin
            state_q    <= S_RUN;
            tick_q     <= '0;
            pend_vld_q <= 1'b0;
            if (key_ok) dir_q <= key_dir;
          end
        end
        S_RUN: begin
          if (step) begin
            tick_q     <= '0;
            pend_vld_q <= 1'b0;
            grow_q     <= 1'b0;
            if (wall_hit || self_hit) begin
              state_q <= S_DEAD;
            end else begin
              dir_q      <= eff_dir;
              seg_x_q[0] <= head_x_d;
              seg_y_q[0] <= head_y_d;
              for (int i = 1; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_q[i-1];
                seg_y_q[i] <= seg_y_q[i-1];
              end
              if (grow_apply) len_q <= len_q + 5'd1;
              move_tick_q <= 1'b1;
            end
          end else begin
            tick_q <= tick_q + CW'(1);
            if (!pend_vld_q && key_ok) begin
              pend_q     <= key_dir;
              pend_vld_q <= 1'b1;
            end
            if (Body_add_sig) grow_q <= 1'b1;
          end
        end
        S_DEAD: begin
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Registered display probe against the store as it stands at the edge.
  always_ff @(posedge Clk_50mhz) begin
    if (!Rst_n) begin
      is_head_q <= 1'b0;
      is_body_q <= 1'b0;
    end else begin
      is_head_q <= (Query_x == seg_x_q[0]) && (Query_y == seg_y_q[0]);
      is_body_q <= body_hit;
    end
  end

  assign Head_x    = seg_x_q[0];
  assign Head_y    = {1'b0, seg_y_q[0]};
  assign Snake_len = len_q;
  assign Move_tick = move_tick_q;
  assign Game_over = (state_q == S_DEAD);
  assign Is_head   = is_head_q;
  assign Is_body   = is_body_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl with TICK_DIV=4, MAX_LEN=16.
`timescale 1ns/1ps
module tb_snake_move_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       k_up, k_down, k_left, k_right;
  logic       restart, body_add;
  logic [5:0] qx;
  logic [4:0] qy;
  logic [5:0] hx, hy;
  logic [4:0] slen;
  logic       mtick, gover, ihead, ibody;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n;

  snake_move_ctrl #(.TICK_DIV(4), .MAX_LEN(16)) dut (
    .Clk_50mhz   (clk),
    .Rst_n       (rst_n),
    .Key_up      (k_up),
    .Key_down    (k_down),
    .Key_left    (k_left),
    .Key_right   (k_right),
    .Restart     (restart),
    .Body_add_sig(body_add),
    .Query_x     (qx),
    .Query_y     (qy),
    .Head_x      (hx),
    .Head_y      (hy),
    .Snake_len   (slen),
    .Move_tick   (mtick),
    .Game_over   (gover),
    .Is_head     (ihead),
    .Is_body     (ibody)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic u, input logic d, input logic l, input logic r,
                       input logic rs, input logic ba);
    k_up = u; k_down = d; k_left = l; k_right = r; restart = rs; body_add = ba;
    tick();
    k_up = 0; k_down = 0; k_left = 0; k_right = 0; restart = 0; body_add = 0;
  endtask

  // One full step period starting right after a step (counter at 0);
  // optional key in the first cycle, optional grow pulse coincident with the step.
  task automatic do_step(input logic u, input logic d, input logic l, input logic r,
                         input logic grow);
    k_up = u; k_down = d; k_left = l; k_right = r;
    tick();
    k_up = 0; k_down = 0; k_left = 0; k_right = 0;
    tick();
    tick();
    body_add = grow;
    tick();
    body_add = 0;
  endtask

  task automatic wait_step(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (mtick !== 1'b1 && cycles < 10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; k_up = 0; k_down = 0; k_left = 0; k_right = 0;
    restart = 0; body_add = 0; qx = 6'd0; qy = 5'd0;
    tick();
    tick();
    check("rst_head_x", 32'(hx), 32'd28);
    check("rst_head_y", 32'(hy), 32'd13);
    check("rst_len", 32'(slen), 32'd3);
    check("rst_move_tick", 32'(mtick), 32'd0);
    check("rst_game_over", 32'(gover), 32'd0);
    check("rst_is_head", 32'(ihead), 32'd0);
    check("rst_is_body", 32'(ibody), 32'd0);
    rst_n = 1;

    // Probe in IDLE
    qx = 6'd28; qy = 5'd13; tick();
    check("probe_head_is_head", 32'(ihead), 32'd1);
    check("probe_head_is_body", 32'(ibody), 32'd0);
    qx = 6'd26; qy = 5'd13; tick();
    check("probe_tail_is_body", 32'(ibody), 32'd1);
    check("probe_tail_is_head", 32'(ihead), 32'd0);
    qx = 6'd0; qy = 5'd0; tick();
    check("probe_empty_is_head", 32'(ihead), 32'd0);
    check("probe_empty_is_body", 32'(ibody), 32'd0);

    // Start moving right, three steps 4 cycles apart
    pulse(0, 0, 0, 1, 0, 0);
    for (int s = 1; s <= 3; s++) begin
      wait_step(n);
      check("run_step_gap", 32'(n), 32'd4);
      check("run_head_x", 32'(hx), 32'(28 + s));
      check("run_head_y", 32'(hy), 32'd13);
    end
    check("run_len", 32'(slen), 32'd3);

    // Reverse key ignored, following up accepted
    pulse(0, 0, 1, 0, 0, 0);
    pulse(1, 0, 0, 0, 0, 0);
    wait_step(n);
    check("turn_step_gap", 32'(n), 32'd2);
    check("turn_head_x", 32'(hx), 32'd31);
    check("turn_head_y", 32'(hy), 32'd12);
    // Up and left together: up wins
    pulse(1, 0, 1, 0, 0, 0);
    wait_step(n);
    check("prio_step_gap", 32'(n), 32'd3);
    check("prio_head_x", 32'(hx), 32'd31);
    check("prio_head_y", 32'(hy), 32'd11);

    // Growth: pending request consumed at one step only
    pulse(0, 0, 0, 0, 0, 1);
    wait_step(n);
    check("grow_gap", 32'(n), 32'd3);
    check("grow_len_1", 32'(slen), 32'd4);
    wait_step(n);
    check("grow_len_2", 32'(slen), 32'd4);
    check("grow_head_y", 32'(hy), 32'd9);
    // Grow pulse coincident with the step
    do_step(0, 0, 0, 0, 1);
    check("coinc_move_tick", 32'(mtick), 32'd1);
    check("coinc_len", 32'(slen), 32'd5);
    check("coinc_head_y", 32'(hy), 32'd8);
    // Turn left and grow on every step: saturates at 16
    for (int k = 0; k < 14; k++) begin
      do_step(0, 0, (k == 0), 0, 1);
      check("sat_move_tick", 32'(mtick), 32'd1);
      check("sat_len", 32'(slen), 32'((5 + k + 1 > 16) ? 16 : 5 + k + 1));
    end
    check("sat_head_x", 32'(hx), 32'd17);
    check("sat_head_y", 32'(hy), 32'd8);

    // Reset in the middle of RUN
    rst_n = 0;
    tick();
    rst_n = 1;
    check("midrst_head_x", 32'(hx), 32'd28);
    check("midrst_head_y", 32'(hy), 32'd13);
    check("midrst_len", 32'(slen), 32'd3);
    check("midrst_move_tick", 32'(mtick), 32'd0);
    for (int k = 0; k < 6; k++) tick();
    check("idle_no_move", 32'(hx), 32'd28);

    // Right wall
    pulse(0, 0, 0, 1, 0, 0);
    for (int s = 1; s <= 11; s++) begin
      wait_step(n);
      check("wall_step_gap", 32'(n), 32'd4);
      check("wall_head_x", 32'(hx), 32'(28 + s));
    end
    tick(); tick(); tick();
    check("wall_not_yet_dead", 32'(gover), 32'd0);
    tick();
    check("wall_game_over", 32'(gover), 32'd1);
    check("wall_no_move_tick", 32'(mtick), 32'd0);
    check("wall_head_x_hold", 32'(hx), 32'd39);
    check("wall_head_y_hold", 32'(hy), 32'd13);
    for (int k = 0; k < 5; k++) tick();
    check("dead_frozen_x", 32'(hx), 32'd39);
    check("dead_no_tick", 32'(mtick), 32'd0);
    pulse(1, 0, 0, 0, 0, 0);
    check("dead_key_ignored", 32'(gover), 32'd1);
    pulse(0, 0, 0, 0, 1, 0);
    check("restart_game_over", 32'(gover), 32'd0);
    check("restart_head_x", 32'(hx), 32'd28);
    check("restart_head_y", 32'(hy), 32'd13);
    check("restart_len", 32'(slen), 32'd3);

    // Length 5, up/left/down runs into own body
    pulse(0, 0, 0, 1, 0, 0);
    do_step(0, 0, 0, 0, 1);
    do_step(0, 0, 0, 0, 1);
    check("self_len5", 32'(slen), 32'd5);
    check("self_head_x0", 32'(hx), 32'd30);
    do_step(1, 0, 0, 0, 0);
    check("self_up_y", 32'(hy), 32'd12);
    do_step(0, 0, 1, 0, 0);
    check("self_left_x", 32'(hx), 32'd29);
    do_step(0, 1, 0, 0, 0);
    check("self_game_over", 32'(gover), 32'd1);
    check("self_no_move_tick", 32'(mtick), 32'd0);
    check("self_head_x_hold", 32'(hx), 32'd29);
    check("self_head_y_hold", 32'(hy), 32'd12);

    // Length 4 square loop chasing the tail
    pulse(0, 0, 0, 0, 1, 0);
    pulse(0, 0, 0, 1, 0, 0);
    do_step(0, 0, 0, 0, 1);
    check("loop_len4", 32'(slen), 32'd4);
    for (int r = 0; r < 2; r++) begin
      do_step(1, 0, 0, 0, 0);
      check("loop_tick_up", 32'(mtick), 32'd1);
      do_step(0, 0, 1, 0, 0);
      check("loop_tick_left", 32'(mtick), 32'd1);
      do_step(0, 1, 0, 0, 0);
      check("loop_tick_down", 32'(mtick), 32'd1);
      do_step(0, 0, 0, 1, 0);
      check("loop_tick_right", 32'(mtick), 32'd1);
    end
    check("loop_alive", 32'(gover), 32'd0);
    check("loop_head_x", 32'(hx), 32'd29);
    check("loop_head_y", 32'(hy), 32'd13);
    qx = 6'd29; qy = 5'd12; tick();
    check("loop_probe_tail_body", 32'(ibody), 32'd1);
    check("loop_probe_tail_head", 32'(ihead), 32'd0);
    qx = 6'd29; qy = 5'd13; tick();
    check("loop_probe_head", 32'(ihead), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/snake_move_ctrl.md
SNAKE_MOVE_CTRL -- requirements
Module: snake_move_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12_500_000, clock cycles per move step (4 moves/s at 50 MHz); minimum legal value 2.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum segment count including head.
REQ-003 SHALL have port Clk_50mhz  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port Rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have ports Key_up, Key_down, Key_left, Key_right  input  1 each  debounced single-cycle direction pulses.
REQ-006 SHALL have port Restart  input  1  single-cycle pulse, DEAD to IDLE.
REQ-007 SHALL have port Body_add_sig  input  1  single-cycle grow request from the apple generator.
REQ-008 SHALL have ports Query_x  input  6 and Query_y  input  5  grid cell probed by the display.
REQ-009 SHALL have ports Head_x  output  6 and Head_y  output  6  current head cell; Head_y[5] always 0.
REQ-010 SHALL have port Snake_len  output  5  active segment count.
REQ-011 SHALL have port Move_tick  output  1  one-cycle pulse in the cycle after each committed move.
REQ-012 SHALL have port Game_over  output  1  high in DEAD.
REQ-013 SHALL have ports Is_head, Is_body  output  1 each  probe result for Query_x/Query_y.

Function
REQ-014 Grid SHALL be x 0..39, y 0..29; segment store SHALL be MAX_LEN entries of {x[5:0], y[4:0]}, entry 0 = head.
REQ-015 SHALL have states IDLE, RUN, DEAD; IDLE->RUN on any Key_* pulse; RUN->DEAD on collision; DEAD->IDLE on Restart; all other inputs ignored in IDLE/DEAD except keys setting direction in IDLE.
REQ-016 Tick counter SHALL count 0..TICK_DIV-1 only in RUN, wrap to 0, and flag a step when at TICK_DIV-1; counter SHALL clear on entry to RUN.
REQ-017 Direction keys SHALL be prioritised up>down>left>right when simultaneous; a key reversing the current committed direction SHALL be ignored.
REQ-018 Only the first accepted key between two steps SHALL be latched as pending direction; the pending direction SHALL be committed at the step.
REQ-019 At a step, next head SHALL be head plus one cell in the committed direction (up = y-1, right = x+1).
REQ-020 Wall collision: next x outside 0..39 or next y outside 0..29 (including 0-1 underflow) SHALL enter DEAD with no position change.
REQ-021 Self collision: next head equal to any active entry 1..Snake_len-1 SHALL enter DEAD with no position change, except the tail entry when no growth applies this step (tail vacates).
REQ-022 Body_add_sig SHALL set grow_pending; a pulse coincident with a step SHALL apply to that step; grow_pending SHALL clear when consumed.
REQ-023 On a non-colliding step, entries SHALL shift (entry i <= entry i-1), entry 0 <= next head; Snake_len SHALL increment if growth applies and Snake_len < MAX_LEN, else hold (saturate, request discarded).
REQ-024 Move_tick SHALL pulse exactly one cycle after each committed step, with Head_x/Head_y already updated; no pulse on collision.
REQ-025 Is_head/Is_body SHALL be registered, one-cycle latency: Is_head = query equals entry 0; Is_body = query equals an active entry 1..Snake_len-1; both SHALL reflect the store at the sampling edge.
REQ-026 Game_over SHALL be 1 exactly while in DEAD; store and Head_x/Head_y SHALL freeze in DEAD.
REQ-027 Restart SHALL restore head position, direction, length and store to reset values and clear grow_pending.

Reset
REQ-028 With Rst_n low at an edge: state IDLE, head (28,13), entries 1,2 = (27,13),(26,13), other entries (0,0), Snake_len 3, direction right, no pending key, grow_pending 0, tick counter 0, Move_tick 0, Game_over 0, Is_head 0, Is_body 0.
REQ-029 Reset mid-RUN or mid-DEAD SHALL take effect at the next edge, overriding any step or key pulse in that cycle.

Verification (TICK_DIV=4)
REQ-030 Reset, Key_right pulse, run 3 steps -> Head_x 29,30,31, Head_y 13, Move_tick 3 single pulses 4 cycles apart, Snake_len 3.
REQ-031 In RUN heading right, Key_left then Key_up within one step period -> left ignored, next step Head (x,12); Key_up+Key_left same cycle -> up taken.
REQ-032 Body_add_sig pulse, two steps -> Snake_len 4 after first step, still 4 after second; Body_add_sig coincident with step -> growth at that step; 14 further growths -> Snake_len saturates at 16.
REQ-033 Head driven to x=39 heading right, next step -> Game_over 1, Head_x stays 39, no Move_tick; Restart -> IDLE, head (28,13), Snake_len 3.
REQ-034 Length 5 snake steered up, left, down -> head enters body cell -> DEAD; length 4 square loop chasing its own tail without growth -> no collision.
REQ-035 Query_x/Query_y = head cell -> Is_head 1 next cycle; = (26,13) after reset -> Is_body 1; = (0,0) -> both 0.
